// File: rtl/tag_fifo.sv
// tag_fifo: free-tag pool that hands out rd_tags at dispatch and takes them back at retire.
module tag_fifo #(
  parameter int TAG_W           = 6,
  parameter int DEPTH           = 64,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_valid,
  input  logic             release_en,
  input  logic [TAG_W-1:0] release_tag,
  input  logic             flush,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic [TAG_W:0]   count,
  output logic             underflow_err,
  output logic             overflow_err
);
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             uf_q, uf_d, of_q, of_d;
  logic             do_alloc, do_release;
  assign empty         = count_q == '0;
  assign full          = count_q == (TAG_W+1)'(DEPTH);
  assign almost_empty  = count_q <= (TAG_W+1)'(ALMOST_EMPTY_TH);
  assign alloc_valid   = !empty;
  assign alloc_tag     = mem_q[rd_ptr_q];
  assign count         = count_q;
  assign underflow_err = uf_q;
  assign overflow_err  = of_q;
  // A release into a full pool is still legal when an alloc frees a slot in the same cycle.
  assign do_alloc   = alloc_en && !empty;
  assign do_release = release_en && (!full || do_alloc);
  // Next-state: flush rebuilds the ordered pool and ignores alloc/release; error flags persist.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    uf_d     = uf_q;
    of_d     = of_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = TAG_W'(i);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = (TAG_W+1)'(DEPTH);
    end else begin
      if (do_release) mem_d[wr_ptr_q] = release_tag;
      rd_ptr_d = rd_ptr_q + TAG_W'(do_alloc);
      wr_ptr_d = wr_ptr_q + TAG_W'(do_release);
      count_d  = count_q - (TAG_W+1)'(do_alloc) + (TAG_W+1)'(do_release);
      uf_d     = uf_q || (alloc_en && empty);
      of_d     = of_q || (release_en && !do_release);
    end
  end
  // State register: reset restores the pool and is the only way to clear the error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= (TAG_W+1)'(DEPTH);
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end
endmodule

// File: tb/tb_tag_fifo.sv
// tb_tag_fifo: directed checks of the free-tag pool.
module tb_tag_fifo;
  logic       clk = 1'b0;
  logic       rst, alloc_en, release_en, flush;
  logic [5:0] release_tag, alloc_tag;
  logic       alloc_valid, empty, full, almost_empty, underflow_err, overflow_err;
  logic [6:0] count;
  int         tests = 0, fails = 0;
  tag_fifo dut (
    .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_tag(alloc_tag),
    .alloc_valid(alloc_valid), .release_en(release_en), .release_tag(release_tag),
    .flush(flush), .empty(empty), .full(full), .almost_empty(almost_empty),
    .count(count), .underflow_err(underflow_err), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask
  task automatic drv(input logic a, input logic r, input logic [5:0] t, input logic f);
    alloc_en = a; release_en = r; release_tag = t; flush = f;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 64);
    chk("rst_tag", 32'(alloc_tag), 0);
    chk("rst_valid", 32'(alloc_valid), 1);
    chk("rst_full", 32'(full), 1);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_ae", 32'(almost_empty), 0);
    chk("rst_uf", 32'(underflow_err), 0);
    chk("rst_of", 32'(overflow_err), 0);
    for (int i = 0; i < 64; i++) begin
      drv(1, 0, 0, 0);
      chk("drain_tag", 32'(alloc_tag), 32'(i));
      chk("drain_ae", 32'(almost_empty), 32'((64 - i) <= 2));
      tick();
    end
    drv(0, 0, 0, 0);
    chk("drained_empty", 32'(empty), 1);
    chk("drained_count", 32'(count), 0);
    chk("drained_valid", 32'(alloc_valid), 0);
    chk("drained_uf", 32'(underflow_err), 0);
    drv(0, 1, 5, 0); tick();
    drv(0, 1, 17, 0); tick();
    drv(0, 1, 63, 0); tick();
    chk("rel3_count", 32'(count), 3);
    drv(1, 0, 0, 0);
    chk("fifo_tag0", 32'(alloc_tag), 5);  tick();
    chk("fifo_tag1", 32'(alloc_tag), 17); tick();
    chk("fifo_tag2", 32'(alloc_tag), 63); tick();
    drv(0, 0, 0, 0);
    chk("fifo_count", 32'(count), 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 6'(50 + i), 0);
      tick();
    end
    chk("ten_count", 32'(count), 10);
    for (int i = 0; i < 100; i++) begin
      drv(1, 1, 40, 0);
      chk("steady_tag", 32'(alloc_tag), i < 10 ? 32'(50 + i) : 40);
      tick();
      chk("steady_count", 32'(count), 10);
    end
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0);
    chk("redrain_count", 32'(count), 0);
    chk("redrain_uf", 32'(underflow_err), 0);
    drv(1, 1, 9, 0); tick();
    drv(0, 0, 0, 0);
    chk("uf_flag", 32'(underflow_err), 1);
    chk("uf_count", 32'(count), 1);
    chk("uf_tag", 32'(alloc_tag), 9);
    chk("uf_of", 32'(overflow_err), 0);
    drv(1, 0, 0, 0);
    chk("uf_next_tag", 32'(alloc_tag), 9);
    tick();
    drv(0, 0, 0, 0);
    chk("uf_next_count", 32'(count), 0);
    drv(0, 0, 0, 1); tick();
    drv(0, 0, 0, 0);
    chk("flush_full", 32'(full), 1);
    chk("flush_keep_uf", 32'(underflow_err), 1);
    drv(0, 1, 3, 0); tick();
    drv(0, 0, 0, 0);
    chk("of_flag", 32'(overflow_err), 1);
    chk("of_count", 32'(count), 64);
    chk("of_tag", 32'(alloc_tag), 0);
    drv(1, 1, 3, 0); tick();
    drv(0, 0, 0, 0);
    chk("full_ar_count", 32'(count), 64);
    chk("full_ar_of", 32'(overflow_err), 1);
    chk("full_ar_tag", 32'(alloc_tag), 1);
    for (int i = 0; i < 63; i++) begin
      drv(1, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0);
    chk("tail_count", 32'(count), 1);
    chk("tail_tag", 32'(alloc_tag), 3);
    drv(0, 0, 0, 1); tick();
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0);
    chk("pre_flush_count", 32'(count), 44);
    chk("pre_flush_tag", 32'(alloc_tag), 20);
    drv(1, 1, 2, 1); tick();
    drv(0, 0, 0, 0);
    chk("flush_count", 32'(count), 64);
    chk("flush_tag", 32'(alloc_tag), 0);
    chk("flush_uf", 32'(underflow_err), 1);
    chk("flush_of", 32'(overflow_err), 1);
    for (int i = 0; i < 64; i++) begin
      drv(1, 0, 0, 0);
      chk("pool_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    drv(0, 0, 0, 0);
    chk("pool_empty", 32'(empty), 1);
    drv(0, 1, 12, 0); tick();
    drv(1, 0, 0, 0);
    rst = 1'b1; tick();
    rst = 1'b0;
    drv(0, 0, 0, 0);
    chk("rst2_uf", 32'(underflow_err), 0);
    chk("rst2_of", 32'(overflow_err), 0);
    chk("rst2_count", 32'(count), 64);
    chk("rst2_tag", 32'(alloc_tag), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
